// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder controller: feeds one digit pair per cycle (LSD first) to a shared
// external BCD digit adder. Optional operand validation with `define BCD_OPERAND_CHECK_EN.
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  START,
   input  logic [4*DIGITS-1:0]   A,
   input  logic [4*DIGITS-1:0]   B,
   input  logic                  CIN,
   output logic [3:0]            ADD_A,
   output logic [3:0]            ADD_B,
   output logic                  ADD_CIN,
   input  logic [3:0]            ADD_SUM,
   input  logic                  ADD_COUT,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [4*DIGITS-1:0]   SUM,
   output logic                  COUT,
   output logic                  ERR
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = $clog2(DIGITS + 1);

   typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;

`ifdef BCD_OPERAND_CHECK_EN
   logic            err_q, err_d;
   logic            bad_operand;

   always_comb begin
      bad_operand = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) bad_operand = 1'b1;
      end
   end

   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

   // Digit-adder operands depend only on registered state, keeping the external
   // adder path free of any loop through the next-state logic.
   always_comb begin
      ADD_A   = 4'd0;
      ADD_B   = 4'd0;
      ADD_CIN = 1'b0;
      if (state_q == ADD) begin
         ADD_CIN = carry_q;
         for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
               ADD_A = a_q[4*i +: 4];
               ADD_B = b_q[4*i +: 4];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef BCD_OPERAND_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (START) begin
               a_d     = A;
               b_d     = B;
               carry_d = CIN;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = ADD;
`ifdef BCD_OPERAND_CHECK_EN
               err_d   = 1'b0;
               if (bad_operand) begin
                  err_d   = 1'b1;
                  state_d = FIN;
               end
`endif
            end
         end
         ADD: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (idx_q == IW'(i)) sum_d[4*i +: 4] = ADD_SUM;
            end
            carry_d = ADD_COUT;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(DIGITS - 1)) begin
               cout_d  = ADD_COUT;
               state_d = FIN;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef BCD_OPERAND_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef BCD_OPERAND_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign BUSY = (state_q != IDLE);
   assign DONE = (state_q == FIN);
   assign SUM  = sum_q;
   assign COUT = cout_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl (DIGITS=4) with a behavioural BCD digit adder and a
// decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

   localparam int D = 4;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b1;
   logic          START = 1'b0;
   logic [15:0]   A = '0, B = '0;
   logic          CIN = 1'b0;
   logic [3:0]    ADD_A, ADD_B, ADD_SUM;
   logic          ADD_CIN, ADD_COUT;
   logic          BUSY, DONE, COUT, ERR;
   logic [15:0]   SUM;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   always #5 CLK = ~CLK;

   bcd_serial_add_ctrl #(.DIGITS(D)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B), .CIN(CIN),
      .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_CIN(ADD_CIN),
      .ADD_SUM(ADD_SUM), .ADD_COUT(ADD_COUT),
      .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT), .ERR(ERR)
   );

   // Behavioural decimal digit adder.
   logic [4:0] add_raw;
   assign add_raw  = {1'b0, ADD_A} + {1'b0, ADD_B} + {4'd0, ADD_CIN};
   assign ADD_COUT = (add_raw > 5'd9);
   assign ADD_SUM  = (add_raw > 5'd9) ? 4'(add_raw - 5'd10) : add_raw[3:0];

   always @(negedge CLK) if (DONE === 1'b1) done_cnt++;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int bcd2int(input logic [15:0] v);
      int r = 0;
      int p = 1;
      for (int i = 0; i < D; i++) begin
         r += int'(v[4*i +: 4]) * p;
         p *= 10;
      end
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input int n);
      logic [15:0] r = '0;
      int m = n;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   // Issues one addition and returns the captured result, edges-to-DONE (START edge = 1)
   // and whether DONE dropped after one cycle with the result held.
   task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          output logic [15:0] s, output logic c, output logic e,
                          output int lat, output logic held);
      @(negedge CLK);
      A = a; B = b; CIN = cin; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      lat = 1;
      while (DONE !== 1'b1 && lat < 50) begin
         @(posedge CLK); #1;
         lat++;
      end
      s = SUM; c = COUT; e = ERR;
      @(posedge CLK); #1;
      held = (DONE === 1'b0) && (BUSY === 1'b0) && (SUM === s) && (COUT === c);
   endtask

   initial begin
      logic [15:0] s, es, ra, rb;
      logic        c, e, held, rc, ec;
      int          lat, d0, tot;

      vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0};
      vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'h5000, 16'h4999, 1'b1, 16'h0000, 1'b1};
      vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[5] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1};
      vecs[6] = '{16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0};
      vecs[7] = '{16'h0909, 16'h0191, 1'b0, 16'h1100, 1'b0};

      #2 RST_N = 1'b0;
      #3;
      chk("reset_outputs", {SUM, COUT, DONE, ERR, BUSY, ADD_A, ADD_B, ADD_CIN}, '0);
      @(negedge CLK) RST_N = 1'b1;
      repeat (2) @(posedge CLK);
      #1 chk("idle_outputs", {BUSY, DONE, ADD_A, ADD_B, ADD_CIN}, '0);

      for (int i = 0; i < 8; i++) begin
         d0 = done_cnt;
         run_add(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, e, lat, held);
         chk($sformatf("vec%0d_sum", i), {16'd0, s}, {16'd0, vecs[i].sum});
         chk($sformatf("vec%0d_cout", i), {31'd0, c}, {31'd0, vecs[i].cout});
         chk($sformatf("vec%0d_err", i), {31'd0, e}, 32'd0);
         chk($sformatf("vec%0d_latency", i), lat, 5);
         chk($sformatf("vec%0d_hold", i), {31'd0, held}, 32'd1);
         chk($sformatf("vec%0d_done_cnt", i), done_cnt - d0, 1);
      end

      for (int i = 0; i < 40; i++) begin
         ra = '0; rb = '0;
         for (int k = 0; k < D; k++) begin
            ra[4*k +: 4] = 4'($urandom_range(0, 9));
            rb[4*k +: 4] = 4'($urandom_range(0, 9));
         end
         rc  = 1'($urandom_range(0, 1));
         tot = bcd2int(ra) + bcd2int(rb) + int'(rc);
         es  = int2bcd(tot % 10000);
         ec  = (tot >= 10000);
         run_add(ra, rb, rc, s, c, e, lat, held);
         chk($sformatf("rand%0d_result", i), {15'd0, c, s, lat[7:0], 1'b0, e}, {15'd0, ec, es, 8'd5, 1'b0, 1'b0});
      end

      // Repeated START through ADD and into the FIN cycle must be ignored.
      d0 = done_cnt;
      @(negedge CLK);
      A = 16'h1234; B = 16'h5678; CIN = 1'b0; START = 1'b1;
      @(posedge CLK); #1;
      A = 16'h1111; B = 16'h1111; CIN = 1'b1;
      lat = 1;
      while (DONE !== 1'b1 && lat < 50) begin
         @(posedge CLK); #1;
         lat++;
      end
      chk("busy_start_latency", lat, 5);
      @(posedge CLK); #1;
      START = 1'b0;
      chk("fin_start_ignored_busy", {31'd0, BUSY}, 32'd0);
      repeat (2) @(posedge CLK);
      #1;
      chk("busy_start_sum", {16'd0, SUM}, 32'h6912);
      chk("busy_start_cout", {31'd0, COUT}, 32'd0);
      chk("busy_start_one_done", done_cnt - d0, 1);

      // Asynchronous reset during the second ADD cycle.
      @(negedge CLK);
      A = 16'h1234; B = 16'h5678; CIN = 1'b0; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      chk("add_digit0_ports", {23'd0, ADD_A, ADD_B, ADD_CIN}, {23'd0, 4'h4, 4'h8, 1'b0});
      @(posedge CLK); #1;
      chk("add_digit1_ports", {23'd0, ADD_A, ADD_B, ADD_CIN}, {23'd0, 4'h3, 4'h7, 1'b1});
      d0 = done_cnt;
      #2 RST_N = 1'b0;
      #1 chk("midop_reset_outputs", {SUM, COUT, DONE, ERR, BUSY, ADD_A, ADD_B, ADD_CIN}, '0);
      repeat (3) @(posedge CLK);
      @(negedge CLK) RST_N = 1'b1;
      repeat (6) @(posedge CLK);
      #1 chk("midop_reset_no_done", done_cnt - d0, 0);
      chk("midop_reset_idle", {31'd0, BUSY}, 32'd0);
      run_add(16'h0001, 16'h0001, 1'b0, s, c, e, lat, held);
      chk("after_reset_sum", {16'd0, s}, 32'h0002);
      chk("after_reset_latency", lat, 5);

`ifdef BCD_OPERAND_CHECK_EN
      run_add(16'h00A0, 16'h0000, 1'b0, s, c, e, lat, held);
      chk("bad_operand_latency", lat, 1);
      chk("bad_operand_err", {31'd0, e}, 32'd1);
      chk("bad_operand_sum", {15'd0, c, s}, 32'd0);
      chk("bad_operand_hold", {31'd0, held}, 32'd1);
      run_add(16'h0005, 16'h0004, 1'b0, s, c, e, lat, held);
      chk("err_cleared", {15'd0, e, s}, {15'd0, 1'b0, 16'h0009});
`else
      run_add(16'h00A0, 16'h0000, 1'b0, s, c, e, lat, held);
      chk("unchecked_err", {31'd0, e}, 32'd0);
      chk("unchecked_latency", lat, 5);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_serial_add_ctrl.md
BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4; number of BCD digits per operand (legal 2..8).
REQ-002 SHALL have port CLK, input, 1; single clock, rising-edge.
REQ-003 SHALL have port RST_N, input, 1; reset, asynchronous, active-low.
REQ-004 SHALL have port START, input, 1; request an addition, sampled only in IDLE.
REQ-005 SHALL have port A, input, 4*DIGITS; packed BCD operand, digit 0 in [3:0].
REQ-006 SHALL have port B, input, 4*DIGITS; packed BCD operand, same packing as A.
REQ-007 SHALL have port CIN, input, 1; carry into digit 0.
REQ-008 SHALL have port ADD_A, output, 4; current digit of A to the shared 4-bit BCD digit adder.
REQ-009 SHALL have port ADD_B, output, 4; current digit of B to the digit adder.
REQ-010 SHALL have port ADD_CIN, output, 1; carry into the digit adder.
REQ-011 SHALL have port ADD_SUM, input, 4; digit sum from the digit adder, combinational in ADD_A/ADD_B/ADD_CIN.
REQ-012 SHALL have port ADD_COUT, input, 1; decimal carry from the digit adder.
REQ-013 SHALL have port BUSY, output, 1; high whenever state is not IDLE.
REQ-014 SHALL have port DONE, output, 1; one-cycle completion pulse.
REQ-015 SHALL have port SUM, output, 4*DIGITS; packed BCD result.
REQ-016 SHALL have port COUT, output, 1; decimal carry out of the top digit.
REQ-017 SHALL have port ERR, output, 1; invalid-operand flag.

Function
REQ-018 SHALL implement FSM states IDLE, ADD, FIN; IDLE->ADD on START sampled high; ADD->FIN after digit DIGITS-1 is captured; FIN->IDLE unconditionally after one cycle.
REQ-019 SHALL, on the START edge, register A, B and CIN into internal operand and carry registers, clear the digit index to 0, and clear SUM, COUT and ERR.
REQ-020 SHALL, in ADD, drive ADD_A and ADD_B with operand digit[index] and ADD_CIN with the carry register, LSD first.
REQ-021 SHALL, on each ADD edge, write ADD_SUM into SUM digit[index], load ADD_COUT into the carry register, and increment the index.
REQ-022 SHALL drive ADD_A, ADD_B and ADD_CIN to 0 outside ADD.
REQ-023 SHALL set COUT to the final carry register value on entry to FIN.
REQ-024 SHALL assert DONE only in FIN, so latency is START edge + DIGITS + 1 edges.
REQ-025 SHALL hold SUM, COUT and ERR stable from FIN until the next accepted START.
REQ-026 SHALL ignore START while BUSY is high, including a START coinciding with the FIN cycle.
REQ-027 SHALL wrap the index to 0 only via a new START, never modulo in ADD.

Reset
REQ-028 SHALL, on RST_N low, immediately force state IDLE and clear index, operand registers, carry register, SUM, COUT, DONE, ERR and BUSY to 0, independent of CLK.
REQ-029 SHALL, on reset mid-operation, abort with no DONE pulse; the first START after release SHALL start a fresh addition.

Configuration
REQ-030 SHALL, with macro BCD_OPERAND_CHECK_EN defined, on the START edge check every digit of A and B; if any digit exceeds 9, go directly to FIN with ERR=1, SUM=0 and COUT=0, and skip ADD.
REQ-031 SHALL, without BCD_OPERAND_CHECK_EN, tie ERR to 0 and pass all digits to the adder unchecked.

Verification (DIGITS=4, behavioural BCD digit adder attached)
REQ-032 SHALL test A=0x1234, B=0x5678, CIN=0 -> SUM=0x6912, COUT=0, DONE 5 edges after the START edge.
REQ-033 SHALL test A=0x9999, B=0x0001, CIN=0 -> SUM=0x0000, COUT=1, carry rippled through all digits.
REQ-034 SHALL test A=0x5000, B=0x4999, CIN=1 -> SUM=0x0000, COUT=1.
REQ-035 SHALL test a second START during ADD and during FIN -> both ignored, first result unchanged, exactly one DONE.
REQ-036 SHALL test RST_N low on the 2nd ADD cycle -> all outputs 0 at once, no DONE; a subsequent 0x0001+0x0001 -> SUM=0x0002.
REQ-037 SHALL test, with BCD_OPERAND_CHECK_EN defined, A=0x00A0 -> DONE 1 edge after START, ERR=1, SUM=0; with the macro undefined, ERR=0.
